bitslice_seq16: RTL
===================

Name: bitslice_seq16

Overview:
- Shares one 8-bit bitwise logic slice between two 16-bit requesters. Each 16-bit operation is serialised as a low-byte pass followed by a high-byte pass.
- This is the area-reduced, time-multiplexed counterpart of the 16-bit gate-level bitwise units: a single byte-wide slice is sequenced twice.
- Sits between the CPU-side bitwise requesters (port 0: ALU pre-stage, port 1: debug/DMA path) and the shared slice.

Parameters:
- WIDTH, 16, operand/result width; fixed at 2x SLICE.
- SLICE, 8, width of the shared logic slice.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  opcode: 00 NOT a, 01 AND, 10 OR, 11 XOR.
- req0_a  in  16  operand a.
- req0_b  in  16  operand b; ignored for NOT.
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same widths and meaning, requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_out  out  16  result.
- res_id  out  1  index of the requester that issued the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous: state=IDLE, res_valid=0, res_out=0, res_id=0, req*_ready=0, busy=0, last_grant=1 (so requester 0 wins first).
- States: IDLE, LO, HI, DONE. Two-bit encoding from the shared defines.
- IDLE:
  - Arbitration is combinational.
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant (round-robin).
  - reqN_ready=1 only in IDLE and only for the granted N. Never both ready in one cycle.
- Handshake (valid && ready) at cycle T:
  - Latch op, a, b and id; update last_grant; go to LO.
  - reqN_ready is a function of valid; a requester must hold op/a/b stable while valid and not ready.
- LO (T+1): slice computes a[7:0] op b[7:0] into result[7:0]; go to HI.
- HI (T+2): slice computes a[15:8] op b[15:8] into result[15:8]; go to DONE.
- DONE (T+3 onward):
  - res_valid=1; res_out and res_id stable until res_ready.
  - On res_valid && res_ready: go to IDLE and drop res_valid next cycle.
  - res_out holds its last value afterwards.
- Latency and throughput: minimum latency 3 cycles from accept to res_valid. Maximum throughput is 1 operation per 4 cycles. No new request is accepted until the result is consumed.
- Slice input mux: selects the low bytes in LO and the high bytes in HI. In IDLE/DONE the slice input is don't-care; no register loads then.
- Validity rules:
  - A request deasserted before handshake is legal; no side effects.
  - Any state is abandoned immediately on reset (mid-op or mid-DONE); the result is lost and the requester must reissue.
  - res_ready while res_valid=0 is ignored.
  - An op code is always valid (4 codes, 2 bits); no error path.

Optional Feature:
- Macro: BITSLICE_SEQ_PERF_EN.
- Defined:
  - Adds output perf_ops (16 bit). Increments by 1 on each res_valid && res_ready.
  - Wraps FFFF to 0000; reset value 0.
  - Also adds perf_conflicts (16 bit). Increments on each IDLE cycle with req0_valid && req1_valid; wraps; reset 0.
- Undefined: neither port exists and no counter logic is instantiated; all other behaviour is identical.

Decomposition:
- Shared include-guarded defines file, bitslice_defs.vh:
  - opcode constants OP_NOT=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_XOR=2'b11.
  - state encodings S_IDLE, S_LO, S_HI, S_DONE.
- Sub-module logic_slice8 (combinational): 8-bit a, b, op in; 8-bit out. Built from the existing 8-bit gate primitives, with XOR composed from NAND. Instantiated once.
- Sequencer, arbiter and registers live in bitslice_seq16.

Test Plan:
- req0 NOT a=0x00FF, res_ready=1 -> req0_ready at T; res_valid at T+3; res_out=0xFF00, res_id=0; busy high T+1..T+3.
- req1 AND a=0xF0F0 b=0x3C3C -> res_out=0x3030, res_id=1. Then req1 XOR a=0xAAAA b=0xFFFF -> 0x5555.
- Both valid continuously with OR ops (a=0x1200/b=0x0034 on port 0, a=0x0001/b=0x8000 on port 1), from reset -> grants alternate 0,1,0,1. Results 0x1234, 0x8001 alternate with matching res_id. With BITSLICE_SEQ_PERF_EN, perf_conflicts counts the contended IDLE cycles.
- res_ready held low for 5 cycles in DONE -> res_valid, res_out and res_id stable for all 5. Both req*_ready stay 0. Accept occurs only after res_ready.
- Assert reset during HI of an XOR op -> all outputs reach their reset values immediately. After release, req0 is granted first and the aborted result never appears.
- With BITSLICE_SEQ_PERF_EN preloaded near wrap: complete 2 ops from perf_ops=0xFFFF -> reads 0x0000 then 0x0001.

Source files
------------

// File: rtl/bitslice_seq16_pkg.sv
// Widths, opcode and state types for the byte-serial 16-bit bitwise unit.
package bitslice_seq16_pkg;
`include "bitslice_defs.vh"

    localparam int SLICE = 8;
    localparam int WIDTH = 2 * SLICE;

    typedef enum logic [1:0] {
        BS_NOT = `OP_NOT,
        BS_AND = `OP_AND,
        BS_OR  = `OP_OR,
        BS_XOR = `OP_XOR
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = `S_IDLE,
        ST_LO   = `S_LO,
        ST_HI   = `S_HI,
        ST_DONE = `S_DONE
    } state_t;
endpackage

// File: rtl/bitslice_defs.vh
// Opcode and sequencer state encodings shared by the bitslice_seq16 block.
`ifndef BITSLICE_DEFS_VH
`define BITSLICE_DEFS_VH

`define OP_NOT 2'b00
`define OP_AND 2'b01
`define OP_OR  2'b10
`define OP_XOR 2'b11

`define S_IDLE 2'b00
`define S_LO   2'b01
`define S_HI   2'b10
`define S_DONE 2'b11

`endif

// File: rtl/logic_slice8.sv
// Combinational byte-wide bitwise slice (NOT/AND/OR/XOR); XOR is built from four NANDs per bit.
module logic_slice8
    import bitslice_seq16_pkg::*;
(
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  op_t              op,
    output logic [SLICE-1:0] y
);
    logic [SLICE-1:0] not_a;
    logic [SLICE-1:0] and_ab;
    logic [SLICE-1:0] or_ab;
    logic [SLICE-1:0] xor_ab;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            logic nand_ab;
            logic nand_a;
            logic nand_b;
            assign nand_ab     = ~(a[gi] & b[gi]);
            assign nand_a      = ~(a[gi] & nand_ab);
            assign nand_b      = ~(b[gi] & nand_ab);
            assign xor_ab[gi]  = ~(nand_a & nand_b);
            assign not_a[gi]   = ~a[gi];
            assign and_ab[gi]  = a[gi] & b[gi];
            assign or_ab[gi]   = a[gi] | b[gi];
        end
    endgenerate

    always_comb begin
        y = not_a;
        case (op)
            BS_AND:  y = and_ab;
            BS_OR:   y = or_ab;
            BS_XOR:  y = xor_ab;
            default: y = not_a;
        endcase
    end
endmodule

// File: rtl/bitslice_seq16.sv
// Two-requester 16-bit bitwise unit sharing one 8-bit slice over LO/HI passes.
// Optional BITSLICE_SEQ_PERF_EN adds perf_ops / perf_conflicts counters.
module bitslice_seq16
    import bitslice_seq16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_out,
    output logic             res_id,
    output logic             busy
`ifdef BITSLICE_SEQ_PERF_EN
    ,
    output logic [15:0]      perf_ops,
    output logic [15:0]      perf_conflicts
`endif
);
    state_t           state_reg, state_next;
    op_t              op_reg;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic             id_reg, last_grant_reg;
    logic             grant, accept;
    logic [SLICE-1:0] slice_a, slice_b, slice_y;

    // Round-robin only matters under contention; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_reg;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        req0_ready = (state_reg == ST_IDLE) && !reset && req0_valid && !grant;
        req1_ready = (state_reg == ST_IDLE) && !reset && req1_valid && grant;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_LO;
            ST_LO:   state_next = ST_HI;
            ST_HI:   state_next = ST_DONE;
            ST_DONE: if (res_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign slice_a = (state_reg == ST_LO) ? a_reg[SLICE-1:0] : a_reg[WIDTH-1:SLICE];
    assign slice_b = (state_reg == ST_LO) ? b_reg[SLICE-1:0] : b_reg[WIDTH-1:SLICE];

    logic_slice8 u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .op (op_reg),
        .y  (slice_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg         <= BS_NOT;
            a_reg          <= '0;
            b_reg          <= '0;
            res_reg        <= '0;
            id_reg         <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: if (accept) begin
                    op_reg         <= grant ? op_t'(req1_op) : op_t'(req0_op);
                    a_reg          <= grant ? req1_a : req0_a;
                    b_reg          <= grant ? req1_b : req0_b;
                    id_reg         <= grant;
                    last_grant_reg <= grant;
                end
                ST_LO:   res_reg[SLICE-1:0]     <= slice_y;
                ST_HI:   res_reg[WIDTH-1:SLICE] <= slice_y;
                default: ;
            endcase
        end
    end

    assign res_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign res_out   = res_reg;
    assign res_id    = id_reg;

`ifdef BITSLICE_SEQ_PERF_EN
    logic [15:0] perf_ops_reg, perf_conflicts_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ops_reg       <= '0;
            perf_conflicts_reg <= '0;
        end else begin
            if (state_reg == ST_DONE && res_ready) begin
                perf_ops_reg <= perf_ops_reg + 16'd1;
            end
            if (state_reg == ST_IDLE && req0_valid && req1_valid) begin
                perf_conflicts_reg <= perf_conflicts_reg + 16'd1;
            end
        end
    end

    assign perf_ops       = perf_ops_reg;
    assign perf_conflicts = perf_conflicts_reg;
`endif
endmodule
